// File: rtl/mesh_port_fifo_if.sv
// mesh_port_fifo_if: handshake bundle between upstream source, port FIFO and downstream consumer
//   master: environment side (drives up_empty/up_rdata/deq/flush, observes status)
//   slave : FIFO side (pulls upstream via up_deq, presents show-ahead head and status)
interface mesh_port_fifo_if #(parameter int WIDTH = 36, parameter int DEPTH = 4);
  logic                   up_empty;
  logic [WIDTH-1:0]       up_rdata;
  logic                   up_deq;
  logic                   deq;
  logic                   empty;
  logic [WIDTH-1:0]       rdata;
  logic                   flush;
  logic [$clog2(DEPTH):0] count;
  logic                   err_underflow;
  logic [15:0]            stall_cycles;
  modport master (output up_empty, up_rdata, deq, flush,
                  input up_deq, empty, rdata, count, err_underflow, stall_cycles);
  modport slave  (input up_empty, up_rdata, deq, flush,
                  output up_deq, empty, rdata, count, err_underflow, stall_cycles);
endinterface

// File: rtl/mesh_port_fifo.sv
// mesh_port_fifo: show-ahead FIFO that pulls words from an upstream virtual FIFO
//   clk, rst : clock and synchronous active-high reset
//   p        : slave side of mesh_port_fifo_if (upstream pull, downstream pop, flush, status)
module mesh_port_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  mesh_port_fifo_if.slave p
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic [15:0]      stall_q, stall_d;
  logic             empty, full, push, pop, clr;
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == CW'(DEPTH);
    clr      = rst || p.flush;
    // pull decision uses only registered occupancy, so deq never reaches up_deq
    push     = !p.up_empty && !full && !clr;
    pop      = p.deq && !empty;
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
    count_d  = clr ? '0 : count_q + CW'(push) - CW'(pop);
    err_d    = rst ? 1'b0 : p.flush ? err_q : err_q | (p.deq && empty);
    stall_d  = rst ? '0 :
               (!p.flush && full && !p.deq && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    err_q    <= err_d;
    stall_q  <= stall_d;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= p.up_rdata;
  assign p.up_deq        = push;
  assign p.empty         = empty;
  assign p.rdata         = empty ? '0 : mem_q[rd_ptr_q];
  assign p.count         = count_q;
  assign p.err_underflow = err_q;
  assign p.stall_cycles  = stall_q;
endmodule

// File: tb/tb_mesh_port_fifo.sv
// tb_mesh_port_fifo: directed scenarios plus randomized traffic checked against a queue model
module tb_mesh_port_fifo;
  localparam int WIDTH = 36;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mesh_port_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  mesh_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .p(bus.slave));
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] mq[$];
  logic             m_err = 1'b0;
  int               m_stall = 0;
  bit               m_valid = 0;
  logic [WIDTH-1:0] src = '0;
  bit               rand_src = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic ue, input logic d, input logic f, input logic r);
    int  n;
    bit  pu, po;
    logic [WIDTH-1:0] ur;
    ur = ue ? WIDTH'({$urandom, $urandom}) : src;
    bus.up_empty = ue;
    bus.up_rdata = ur;
    bus.deq      = d;
    bus.flush    = f;
    rst          = r;
    #1;
    n  = mq.size();
    pu = !ue && n < DEPTH && !f && !r;
    chk("up_deq", 64'(bus.up_deq), 64'(pu));
    if (m_valid) begin
      chk("count", 64'(bus.count), 64'(n));
      chk("empty", 64'(bus.empty), 64'(n == 0));
      chk("rdata", 64'(bus.rdata), n == 0 ? 64'd0 : 64'(mq[0]));
      chk("err_underflow", 64'(bus.err_underflow), 64'(m_err));
      chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
    end
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_err = 1'b0;
      m_stall = 0;
      m_valid = 1;
    end else if (f) begin
      mq.delete();
    end else begin
      po = d && n > 0;
      if (d && n == 0) m_err = 1'b1;
      if (n == DEPTH && !d && m_stall < 16'hFFFF) m_stall++;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(ur);
    end
    if (pu) src = rand_src ? WIDTH'({$urandom, $urandom}) : src + 1'b1;
    @(negedge clk);
  endtask
  initial begin
    logic [WIDTH-1:0] nxt;
    int dbias, ubias;
    bus.up_empty = 1'b1;
    bus.up_rdata = '0;
    bus.deq      = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_empty", 64'(bus.empty), 64'd1);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    src = 36'h1;
    step(0, 0, 0, 0);
    chk("first_rdata", 64'(bus.rdata), 64'h1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("three_count", 64'(bus.count), 64'd3);
    chk("three_head", 64'(bus.rdata), 64'h1);
    step(0, 0, 0, 1);
    src = 36'h1;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("full_count", 64'(bus.count), 64'd4);
    chk("full_stall", 64'(bus.stall_cycles), 64'd6);
    chk("full_hold", 64'(bus.up_deq), 64'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    chk("stream_count", 64'(bus.count), 64'd3);
    chk("stream_head", 64'(bus.rdata), 64'h7);
    chk("stream_stall", 64'(bus.stall_cycles), 64'd6);
    step(1, 0, 0, 1);
    step(1, 1, 0, 0);
    chk("uf_set", 64'(bus.err_underflow), 64'd1);
    chk("uf_count", 64'(bus.count), 64'd0);
    step(1, 0, 0, 0);
    chk("uf_sticky", 64'(bus.err_underflow), 64'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_empty", 64'(bus.empty), 64'd1);
    chk("flush_rdata", 64'(bus.rdata), 64'd0);
    chk("flush_err_kept", 64'(bus.err_underflow), 64'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_err", 64'(bus.err_underflow), 64'd0);
    chk("mid_rst_stall", 64'(bus.stall_cycles), 64'd0);
    nxt = src;
    step(0, 0, 0, 0);
    chk("post_rst_word", 64'(bus.rdata), 64'(nxt));
    rand_src = 1;
    src = WIDTH'({$urandom, $urandom});
    dbias = 2;
    ubias = 2;
    for (int i = 0; i < 10000; i++) begin
      if (i % 400 == 0) begin
        dbias = $urandom_range(0, 4);
        ubias = $urandom_range(0, 4);
      end
      step(($urandom % 4) >= ubias, ($urandom % 4) < dbias,
           ($urandom % 128) == 0, ($urandom % 1000) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
